// File: rtl/chrono_pkg.sv
// Shared definitions for the chronometer display path: digit types,
// segment constants and the active-low BCD segment table.
package chrono_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] digit_idx_t;

  // Segment codes are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Digit slot whose decimal point separates seconds from hundredths.
  localparam digit_idx_t DP_DIGIT = 2'd2;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder. Non-decimal codes
// (10..15) show a dash so a corrupted digit is visible on the display.
module seg7_decode
  import chrono_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  // Table lookup for 0..9, dash for everything else.
  always_comb begin
    seg = SEG_DASH;
    if (bcd < 4'd10) begin
      seg = SEG_LUT[bcd];
    end
  end

endmodule

// File: rtl/chrono_display_scan.sv
// Time-multiplexed 4-digit 7-segment driver for the chronometer.
// A snapshot of all four digits is taken at each frame start so a frame
// never mixes two counter values. One digit is lit per SCAN_DIV clocks.
// Outputs are registered: they follow the scan index one clock late.
module chrono_display_scan
  import chrono_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  bcd_t       du,
  input  bcd_t       dd,
  input  bcd_t       su,
  input  bcd_t       sd,
  input  logic       blank_lz,
  input  logic       hold,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          frame_start;
  digit_idx_t    idx;
  logic          scanning;     // set by the first tick after reset
  bcd_t          snap_du, snap_dd, snap_su, snap_sd;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  bcd_t          cur_digit;
  logic [6:0]    cur_code;
  logic          blank_digit;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [3:0]    an_n;

  assign tick        = (presc == PRESC_LAST);
  assign frame_start = tick && (idx == 2'd3);

  // Prescaler: counts 0..SCAN_DIV-1, tick on the last count.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Scan index and frame snapshot; idx starts at 3 so the first tick opens a frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= 2'd3;
      scanning <= 1'b0;
      snap_du  <= '0;
      snap_dd  <= '0;
      snap_su  <= '0;
      snap_sd  <= '0;
    end else if (tick) begin
      idx      <= (idx == 2'd3) ? 2'd0 : idx + 2'd1;
      scanning <= 1'b1;
      if (idx == 2'd3) begin
        snap_du <= du;
        snap_dd <= dd;
        snap_su <= su;
        snap_sd <= sd;
      end
    end
  end

  // Blink: frame counter always runs; phase toggles on wrap while held, clears otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
      if (!hold) begin
        blink_phase <= 1'b0;
      end else if (frame_cnt == FRAME_LAST) begin
        blink_phase <= ~blink_phase;
      end
    end
  end

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (cur_code)
  );

  // Active-low view of the digit selected by idx, with blanking and blink applied.
  always_comb begin
    cur_digit = snap_du;
    case (idx)
      2'd0:    cur_digit = snap_du;
      2'd1:    cur_digit = snap_dd;
      2'd2:    cur_digit = snap_su;
      default: cur_digit = snap_sd;
    endcase
    blank_digit = blank_lz && (idx == 2'd3) && (snap_sd == 4'd0);
    seg_n       = blank_digit ? SEG_BLANK : cur_code;
    dp_n        = !((idx == DP_DIGIT) && !blank_digit);
    an_n        = (hold && blink_phase) ? 4'hF : ~(4'b0001 << idx);
    if (!scanning) begin
      seg_n = SEG_BLANK;
      dp_n  = 1'b1;
      an_n  = 4'hF;
    end
  end

  // Output register; polarity is applied only here.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg <= ACTIVE_LOW ? SEG_BLANK : 7'h00;
      dp  <= ACTIVE_LOW;
      an  <= ACTIVE_LOW ? 4'hF : 4'h0;
    end else if (ACTIVE_LOW) begin
      seg <= seg_n;
      dp  <= dp_n;
      an  <= an_n;
    end else begin
      seg <= ~seg_n;
      dp  <= ~dp_n;
      an  <= ~an_n;
    end
  end

endmodule

// File: tb/tb_chrono_display_scan.sv
// Bench for chrono_display_scan: two instances (SCAN_DIV=4/BLINK=2/active-low
// and SCAN_DIV=1/BLINK=1/active-high) driven with the same random digits.
// A cycle-level reference model pushes the expected {seg,dp,an} at every
// clock edge; a monitor on the falling edge pops and compares.
module tb_chrono_display_scan;

  localparam int W = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] du, dd, su, sd;
  logic       blank_lz, hold;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int tests = 0;
  int fails = 0;

  // Model state per instance: edges since reset, frame snapshot, blink phase.
  int         m_cnt [2];
  logic [3:0] snap  [2][4];
  bit         phase [2];

  // Clock and reset
  always #5 clock = ~clock;

  chrono_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)) dut_a (
    .clock(clock), .reset(reset), .du(du), .dd(dd), .su(su), .sd(sd),
    .blank_lz(blank_lz), .hold(hold), .seg(seg_a), .dp(dp_a), .an(an_a)
  );

  chrono_display_scan #(.SCAN_DIV(1), .BLINK_FRAMES(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clock(clock), .reset(reset), .du(du), .dd(dd), .su(su), .sd(sd),
    .blank_lz(blank_lz), .hold(hold), .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  function automatic int sdv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int bfv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected outputs loaded at this edge, from the state after the previous edge.
  function automatic logic [W-1:0] expect_out(input int i);
    logic [6:0] s;
    logic       d;
    logic [3:0] a;
    logic [W-1:0] o;
    int dg;
    bit blank;
    if (reset || m_cnt[i] < sdv(i)) begin
      s = 7'h7F;
      d = 1'b1;
      a = 4'hF;
    end else begin
      dg    = ((m_cnt[i] - sdv(i)) / sdv(i)) % 4;
      blank = blank_lz && (dg == 3) && (snap[i][3] == 4'd0);
      s     = blank ? 7'h7F : ref_seg(snap[i][dg]);
      d     = (dg == 2 && !blank) ? 1'b0 : 1'b1;
      a     = (hold && phase[i]) ? 4'hF : ~(4'b0001 << dg);
    end
    o = {s, d, a};
    if (i == 1) o = ~o;
    return o;
  endfunction

  // Advance the model by one edge: frame starts capture digits and step the blink.
  task automatic advance(input int i);
    int k;
    bit wrap;
    if (reset) begin
      m_cnt[i] = 0;
      phase[i] = 1'b0;
      for (int j = 0; j < 4; j++) snap[i][j] = 4'd0;
    end else begin
      m_cnt[i] = m_cnt[i] + 1;
      if (m_cnt[i] >= sdv(i) && ((m_cnt[i] - sdv(i)) % (4 * sdv(i))) == 0) begin
        k = (m_cnt[i] - sdv(i)) / (4 * sdv(i));
        snap[i][0] = du;
        snap[i][1] = dd;
        snap[i][2] = su;
        snap[i][3] = sd;
        wrap = ((k % bfv(i)) == bfv(i) - 1);
        if (!hold) phase[i] = 1'b0;
        else if (wrap) phase[i] = ~phase[i];
      end
    end
  endtask

  // Scoreboard producer: one expected word per instance per clock edge.
  always @(posedge clock) begin
    exp_q0.push_back(expect_out(0));
    exp_q1.push_back(expect_out(1));
    advance(0);
    advance(1);
  end

  // Monitor: compare DUT outputs away from the active edge.
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      tests++;
      if ({seg_a, dp_a, an_a} !== e) begin
        fails++;
        $display("FAIL scan_a t=%0t got seg=%b dp=%b an=%b exp seg=%b dp=%b an=%b",
                 $time, seg_a, dp_a, an_a, e[11:5], e[4], e[3:0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      tests++;
      if ({seg_b, dp_b, an_b} !== e) begin
        fails++;
        $display("FAIL scan_b t=%0t got seg=%b dp=%b an=%b exp seg=%b dp=%b an=%b",
                 $time, seg_b, dp_b, an_b, e[11:5], e[4], e[3:0]);
      end
    end
  end

  // Driver: occasionally change one digit or the blanking control.
  task automatic rand_inputs();
    if ($urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 3))
        0:       du = 4'($urandom_range(0, 15));
        1:       dd = 4'($urandom_range(0, 15));
        2:       su = 4'($urandom_range(0, 15));
        default: sd = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      endcase
    end
    if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
  endtask

  task automatic run_random(input int cycles);
    repeat (cycles) begin
      @(negedge clock);
      rand_inputs();
    end
  endtask

  // Stimulus sequence and final report.
  initial begin
    du = 4'd4; dd = 4'd3; su = 4'd2; sd = 4'd1;
    blank_lz = 1'b0;
    hold     = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    // Mid-frame digit change followed by random traffic.
    repeat (5) @(negedge clock);
    du = 4'd7;
    run_random(500);

    // Dash and leading-zero blanking.
    du = 4'hC; sd = 4'd0; blank_lz = 1'b1;
    repeat (40) @(negedge clock);
    blank_lz = 1'b0;
    repeat (40) @(negedge clock);

    // Hold blink for eight frames, then release.
    hold = 1'b1;
    run_random(8 * 16);
    hold = 1'b0;
    run_random(40);

    // Reset pulse mid-scan, then resume.
    repeat ($urandom_range(1, 15)) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    run_random(80);

    // Hold re-entry after reset.
    hold = 1'b1;
    run_random(100);
    hold = 1'b0;
    run_random(40);

    repeat (2) @(negedge clock);
    #1;
    tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      fails++;
      $display("FAIL drain got q0=%0d q1=%0d exp 0", exp_q0.size(), exp_q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
